// File: rtl/bp_tlb_page_walker.sv
// Sv39 page-table walker: services one TLB miss at a time and returns either a
// leaf entry for the TLB write port or a one-cycle page-fault pulse.
module bp_tlb_page_walker #(
  parameter int unsigned vtag_width_p = 27,
  parameter int unsigned ptag_width_p = 28,
  parameter int unsigned pte_width_p  = 64,
  parameter int unsigned levels_p     = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic [ptag_width_p-1:0]  base_ppn_i,
  input  logic                     miss_v_i,
  input  logic [vtag_width_p-1:0]  miss_vtag_i,
  output logic                     ready_o,
  output logic                     mem_v_o,
  output logic [ptag_width_p+11:0] mem_addr_o,
  input  logic                     mem_ready_i,
  input  logic                     mem_data_v_i,
  input  logic [pte_width_p-1:0]   mem_data_i,
  output logic                     fill_v_o,
  output logic [vtag_width_p-1:0]  fill_vtag_o,
  output logic [ptag_width_p+3:0]  fill_entry_o,
  output logic                     fault_v_o,
  output logic [vtag_width_p-1:0]  fault_vtag_o
);

  localparam int unsigned LvlW = (levels_p > 1) ? $clog2(levels_p) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StFill,
    StFault,
    StDrain
  } state_e;

  state_e                  state_q;
  logic [vtag_width_p-1:0] vtag_q;
  logic [ptag_width_p-1:0] ppn_q;
  logic [LvlW-1:0]         level_q;
  logic [ptag_width_p+3:0] entry_q;

  logic                    pte_v, pte_r, pte_w, pte_x, pte_u;
  logic [ptag_width_p-1:0] pte_ppn, lvl_mask, vtag_ext, leaf_ptag;
  logic                    pte_invalid, pte_pointer, pte_misaligned;
  logic [8:0]              vpn_slice;
  logic                    unused_pte;

  // Reserved/software PTE bits play no part in the walk.
  assign unused_pte = ^{mem_data_i[pte_width_p-1:10+ptag_width_p], mem_data_i[9:5]};

  always_comb begin
    pte_v          = mem_data_i[0];
    pte_r          = mem_data_i[1];
    pte_w          = mem_data_i[2];
    pte_x          = mem_data_i[3];
    pte_u          = mem_data_i[4];
    pte_ppn        = mem_data_i[10 +: ptag_width_p];
    // Low 9*level bits of the PPN come from the VPN on a superpage.
    lvl_mask       = (ptag_width_p'(1) << (9 * level_q)) - ptag_width_p'(1);
    vtag_ext       = ptag_width_p'(vtag_q);
    leaf_ptag      = (pte_ppn & ~lvl_mask) | (vtag_ext & lvl_mask);
    pte_invalid    = ~pte_v | (pte_w & ~pte_r);
    pte_pointer    = ~pte_r & ~pte_w & ~pte_x;
    pte_misaligned = (level_q != '0) && ((pte_ppn & lvl_mask) != '0);
    vpn_slice      = vtag_q[9 * level_q +: 9];
  end

  assign ready_o      = (state_q == StIdle);
  assign mem_v_o      = (state_q == StSend);
  assign mem_addr_o   = {ppn_q, vpn_slice, 3'b000};
  assign fill_v_o     = (state_q == StFill) & ~flush_i;
  assign fault_v_o    = (state_q == StFault) & ~flush_i;
  assign fill_vtag_o  = vtag_q;
  assign fault_vtag_o = vtag_q;
  assign fill_entry_o = entry_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      vtag_q  <= '0;
      ppn_q   <= '0;
      level_q <= '0;
      entry_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss_v_i && !flush_i) begin
            vtag_q  <= miss_vtag_i;
            ppn_q   <= base_ppn_i;
            level_q <= LvlW'(levels_p - 1);
            state_q <= StSend;
          end
        end
        StSend: begin
          // A request already handed to memory must have its response drained.
          if (flush_i) begin
            state_q <= mem_ready_i ? StDrain : StIdle;
          end else if (mem_ready_i) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (mem_data_v_i) begin
            if (flush_i) begin
              state_q <= StIdle;
            end else if (pte_invalid) begin
              state_q <= StFault;
            end else if (pte_pointer) begin
              if (level_q == '0) begin
                state_q <= StFault;
              end else begin
                level_q <= level_q - 1'b1;
                ppn_q   <= pte_ppn;
                state_q <= StSend;
              end
            end else if (pte_misaligned) begin
              state_q <= StFault;
            end else begin
              entry_q <= {leaf_ptag, pte_u, pte_x, pte_w, pte_r};
              state_q <= StFill;
            end
          end else if (flush_i) begin
            state_q <= StDrain;
          end
        end
        StFill, StFault: state_q <= StIdle;
        StDrain: begin
          if (mem_data_v_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_tlb_page_walker.sv
// Bench for bp_tlb_page_walker: directed and randomized Sv39 walks against a
// behavioural page-table model with a latency/back-pressure memory responder.
module tb_bp_tlb_page_walker;

  logic        clk_i = 1'b0;
  logic        reset_n_i, flush_i, miss_v_i, mem_ready_i, mem_data_v_i;
  logic [27:0] base_ppn_i;
  logic [26:0] miss_vtag_i;
  logic [63:0] mem_data_i;
  logic        ready_o, mem_v_o, fill_v_o, fault_v_o;
  logic [39:0] mem_addr_o;
  logic [26:0] fill_vtag_o, fault_vtag_o;
  logic [31:0] fill_entry_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bp_tlb_page_walker dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .flush_i      (flush_i),
    .base_ppn_i   (base_ppn_i),
    .miss_v_i     (miss_v_i),
    .miss_vtag_i  (miss_vtag_i),
    .ready_o      (ready_o),
    .mem_v_o      (mem_v_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_data_v_i (mem_data_v_i),
    .mem_data_i   (mem_data_i),
    .fill_v_o     (fill_v_o),
    .fill_vtag_o  (fill_vtag_o),
    .fill_entry_o (fill_entry_o),
    .fault_v_o    (fault_v_o),
    .fault_vtag_o (fault_vtag_o)
  );

  logic [63:0] mem [logic [39:0]];

  // Model expectations
  int              exp_n;
  logic [2:0][39:0] exp_addr;
  bit              exp_fault;
  logic [31:0]     exp_entry;
  // Observations from run_walk
  int              got_n, got_fill, got_fault, got_lat;
  logic [2:0][39:0] got_addr;
  logic [31:0]     got_entry;
  logic [26:0]     got_vtag;
  bit              proto_bad;

  function automatic logic [63:0] mem_rd(input logic [39:0] a);
    if (mem.exists(a)) return mem[a];
    return 64'd0;
  endfunction

  function automatic logic [39:0] pte_addr(input logic [27:0] ppn, input logic [26:0] vt,
                                           input int lvl);
    return 40'(ppn) * 40'd4096 + 40'((vt >> (9 * lvl)) % 512) * 40'd8;
  endfunction

  // flags = {U, X, W, R, V}
  function automatic logic [63:0] mk_pte(input logic [27:0] ppn, input logic [4:0] flags);
    return {26'd0, ppn, 5'd0, flags};
  endfunction

  task automatic ref_walk(input logic [26:0] vtag, input logic [27:0] base);
    longint unsigned ppn, span, pp, vt;
    logic [63:0] pte;
    logic [39:0] a;
    exp_n = 0; exp_addr = '0; exp_fault = 1'b1; exp_entry = '0;
    ppn = base; vt = vtag;
    for (int lvl = 2; lvl >= 0; lvl--) begin
      a = pte_addr(28'(ppn), vtag, lvl);
      exp_addr[exp_n] = a;
      exp_n++;
      pte = mem_rd(a);
      if (!pte[0] || (pte[2] && !pte[1])) return;
      pp = pte[37:10];
      if (!pte[1] && !pte[3]) begin
        if (lvl == 0) return;
        ppn = pp;
      end else begin
        span = 64'd1 << (9 * lvl);
        if (pp % span != 0) return;
        exp_fault = 1'b0;
        exp_entry = {28'(pp + vt % span), pte[4], pte[3], pte[2], pte[1]};
        return;
      end
    end
  endtask

  task automatic run_walk(input logic [26:0] vtag, input logic [27:0] base,
                          input int stall_lo, input int stall_hi,
                          input int lat_lo, input int lat_hi);
    int stall, wait_n;
    bit pend, in_req, done;
    logic [39:0] hold, raddr;
    got_n = 0; got_addr = '0; got_fill = 0; got_fault = 0; got_entry = '0; got_vtag = '0;
    got_lat = -1; proto_bad = 1'b0;
    stall = int'($urandom_range(stall_hi, stall_lo));
    wait_n = 0; pend = 1'b0; in_req = 1'b0; done = 1'b0; hold = '0; raddr = '0;
    @(negedge clk_i);
    if (!ready_o) proto_bad = 1'b1;
    miss_v_i = 1'b1; miss_vtag_i = vtag; base_ppn_i = base;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk_i);
      miss_v_i = 1'b0; mem_ready_i = 1'b0; mem_data_v_i = 1'b0;
      mem_data_i = {$urandom, $urandom};
      base_ppn_i = 28'($urandom);
      if (done) begin
        if (!ready_o) proto_bad = 1'b1;
        break;
      end
      if (ready_o || (fill_v_o && fault_v_o)) proto_bad = 1'b1;
      if (fill_v_o) begin
        got_fill++; got_entry = fill_entry_o; got_vtag = fill_vtag_o; got_lat = cyc; done = 1'b1;
      end
      if (fault_v_o) begin
        got_fault++; got_vtag = fault_vtag_o; got_lat = cyc; done = 1'b1;
      end
      if (pend) begin
        if (wait_n == 0) begin
          mem_data_v_i = 1'b1; mem_data_i = mem_rd(raddr); pend = 1'b0;
        end else begin
          wait_n--;
        end
      end else if (mem_v_o) begin
        if (in_req && mem_addr_o !== hold) proto_bad = 1'b1;
        in_req = 1'b1; hold = mem_addr_o;
        mem_data_v_i = 1'($urandom_range(1, 0));  // stray response while requesting
        if (stall == 0) begin
          mem_ready_i = 1'b1;
          if (got_n < 3) got_addr[got_n] = mem_addr_o;
          got_n++;
          raddr = mem_addr_o; pend = 1'b1; in_req = 1'b0;
          wait_n = int'($urandom_range(lat_hi, lat_lo));
          stall = int'($urandom_range(stall_hi, stall_lo));
        end else begin
          stall--;
        end
      end else if (in_req) begin
        proto_bad = 1'b1;
      end
    end
    mem_data_v_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0; flush_i = 1'b0; miss_v_i = 1'b0; mem_ready_i = 1'b0;
    mem_data_v_i = 1'b0; base_ppn_i = '0; miss_vtag_i = '0; mem_data_i = '0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({ready_o, mem_v_o, fill_v_o, fault_v_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/memv/fill/fault=%b want 1000",
               {ready_o, mem_v_o, fill_v_o, fault_v_o});
    end
    checks++;
    if ({mem_addr_o, fill_entry_o, fill_vtag_o, fault_vtag_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h entry=%h vtag=%h/%h want all 0",
               mem_addr_o, fill_entry_o, fill_vtag_o, fault_vtag_o);
    end
    miss_v_i = 1'b1; miss_vtag_i = 27'h1234567; base_ppn_i = 28'h1;
    @(negedge clk_i);
    miss_v_i = 1'b0; reset_n_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({ready_o, mem_v_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got rdy/memv=%b want 10", {ready_o, mem_v_o});
    end
  endtask

  task automatic test_three_level;
    logic [26:0] vt = 27'h0040201;
    mem.delete();
    mem[pte_addr(28'h80000, vt, 2)] = mk_pte(28'h80001, 5'b00001);
    mem[pte_addr(28'h80001, vt, 1)] = mk_pte(28'h80002, 5'b00001);
    mem[pte_addr(28'h80002, vt, 0)] = mk_pte(28'h12345, 5'b01111);
    ref_walk(vt, 28'h80000);
    run_walk(vt, 28'h80000, 0, 2, 0, 2);
    checks++;
    if ({got_fill, got_fault} !== {32'd1, 32'd0}) begin
      errors++;
      $display("FAIL three_level_events: got fill=%0d fault=%0d want 1/0", got_fill, got_fault);
    end
    checks++;
    if ({got_entry, got_vtag} !== {28'h12345, 4'b0111, vt}) begin
      errors++;
      $display("FAIL three_level_entry: got %h/%h want %h/%h", got_entry, got_vtag,
               {28'h12345, 4'b0111}, vt);
    end
    checks++;
    if ({got_n, got_addr} !== {exp_n, exp_addr} || got_addr[0] !== 40'h80000008) begin
      errors++;
      $display("FAIL three_level_addrs: got n=%0d %h want n=%0d %h", got_n, got_addr,
               exp_n, exp_addr);
    end
    checks++;
    if (proto_bad) begin
      errors++;
      $display("FAIL three_level_proto: got handshake/ready violation want none");
    end
  endtask

  task automatic test_superpage;
    logic [26:0] vt = 27'h00ABCDE;
    mem.delete();
    mem[pte_addr(28'h00777, vt, 2)] = mk_pte(28'h40000, 5'b00011);
    run_walk(vt, 28'h00777, 0, 0, 0, 0);
    checks++;
    if ({got_fill, got_fault, got_entry} !== {32'd1, 32'd0, 28'h006BCDE, 4'b0001}) begin
      errors++;
      $display("FAIL superpage_entry: got fill=%0d fault=%0d entry=%h want 1/0/%h",
               got_fill, got_fault, got_entry, {28'h006BCDE, 4'b0001});
    end
    checks++;
    if (got_lat !== 3) begin
      errors++;
      $display("FAIL min_latency: got fill at cycle %0d want 3", got_lat);
    end
  endtask

  task automatic test_faults;
    logic [26:0] vt = 27'h0040201;
    for (int c = 0; c < 4; c++) begin
      mem.delete();
      case (c)
        0: mem[pte_addr(28'h80000, vt, 2)] = mk_pte(28'h00001, 5'b01110);
        1: mem[pte_addr(28'h80000, vt, 2)] = mk_pte(28'h00000, 5'b00101);
        2: begin
          mem[pte_addr(28'h80000, vt, 2)] = mk_pte(28'h80001, 5'b00001);
          mem[pte_addr(28'h80001, vt, 1)] = mk_pte(28'h80002, 5'b00001);
          mem[pte_addr(28'h80002, vt, 0)] = mk_pte(28'h80003, 5'b00001);
        end
        default: begin
          mem[pte_addr(28'h80000, vt, 2)] = mk_pte(28'h80001, 5'b00001);
          mem[pte_addr(28'h80001, vt, 1)] = mk_pte(28'h00201, 5'b00011);
        end
      endcase
      ref_walk(vt, 28'h80000);
      run_walk(vt, 28'h80000, 0, 1, 0, 1);
      checks++;
      if ({got_fill, got_fault, got_vtag} !== {32'd0, 32'd1, vt}) begin
        errors++;
        $display("FAIL fault_%0d_pulse: got fill=%0d fault=%0d vtag=%h want 0/1/%h",
                 c, got_fill, got_fault, got_vtag, vt);
      end
      checks++;
      if ({got_n, got_addr} !== {exp_n, exp_addr} || proto_bad) begin
        errors++;
        $display("FAIL fault_%0d_walk: got n=%0d %h proto_bad=%0d want n=%0d %h ok",
                 c, got_n, got_addr, proto_bad, exp_n, exp_addr);
      end
    end
  endtask

  task automatic test_stall;
    logic [26:0] vt = 27'h5555555;
    mem.delete();
    mem[pte_addr(28'h00ABC, vt, 2)] = mk_pte(28'h00C0000, 5'b11111);
    ref_walk(vt, 28'h00ABC);
    run_walk(vt, 28'h00ABC, 5, 5, 0, 0);
    checks++;
    if ({got_n, got_addr, proto_bad} !== {exp_n, exp_addr, 1'b0}) begin
      errors++;
      $display("FAIL stall_handshake: got n=%0d %h unstable=%0d want n=%0d %h stable",
               got_n, got_addr, proto_bad, exp_n, exp_addr);
    end
    checks++;
    if ({got_fill, got_entry, got_lat} !== {32'd1, exp_entry, 32'd8}) begin
      errors++;
      $display("FAIL stall_fill: got fill=%0d entry=%h lat=%0d want 1/%h/8",
               got_fill, got_entry, got_lat, exp_entry);
    end
  endtask

  task automatic test_flush;
    logic [26:0] vt = 27'h0012345;
    logic [27:0] b = 28'h0000100;
    logic [39:0] a;
    logic [3:0]  rdy;
    int          ev;
    mem.delete();
    a = pte_addr(b, vt, 2);
    mem[a] = mk_pte(28'h0040000, 5'b00011);
    @(negedge clk_i);
    miss_v_i = 1'b1; miss_vtag_i = vt; base_ppn_i = b; flush_i = 1'b1;
    @(negedge clk_i);
    miss_v_i = 1'b0; flush_i = 1'b0;
    checks++;
    if ({ready_o, mem_v_o} !== 2'b10) begin
      errors++;
      $display("FAIL flush_idle: got rdy/memv=%b want 10", {ready_o, mem_v_o});
    end
    miss_v_i = 1'b1;
    @(negedge clk_i);
    miss_v_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    checks++;
    if ({ready_o, mem_v_o} !== 2'b10) begin
      errors++;
      $display("FAIL flush_send: got rdy/memv=%b want 10", {ready_o, mem_v_o});
    end
    miss_v_i = 1'b1;
    @(negedge clk_i);
    miss_v_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk_i);
    mem_ready_i = 1'b0; flush_i = 1'b1;
    ev = 0; rdy = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      flush_i = 1'b0;
      mem_data_v_i = (i == 2); mem_data_i = mem[a];
      rdy[i] = ready_o;
      ev += int'(fill_v_o) + int'(fault_v_o);
    end
    mem_data_v_i = 1'b0;
    checks++;
    if ({rdy, ev} !== {4'b1000, 32'd0}) begin
      errors++;
      $display("FAIL flush_wait: got ready trace=%b events=%0d want 1000/0", rdy, ev);
    end
    miss_v_i = 1'b1;
    @(negedge clk_i);
    miss_v_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk_i);
    mem_ready_i = 1'b0; mem_data_v_i = 1'b1; mem_data_i = mem[a];
    @(negedge clk_i);
    mem_data_v_i = 1'b0; flush_i = 1'b1;
    #1;
    checks++;
    if ({fill_v_o, fault_v_o} !== 2'b00) begin
      errors++;
      $display("FAIL flush_fill: got fill/fault=%b want 00", {fill_v_o, fault_v_o});
    end
    @(negedge clk_i);
    flush_i = 1'b0;
    b = 28'h0ABCDE; vt = 27'h7FC0A05;
    mem.delete();
    mem[pte_addr(b, vt, 2)] = mk_pte(28'h0033333, 5'b00001);
    mem[pte_addr(28'h0033333, vt, 1)] = mk_pte(28'h0044444, 5'b00001);
    mem[pte_addr(28'h0044444, vt, 0)] = mk_pte(28'h0F0F0F0, 5'b11011);
    ref_walk(vt, b);
    run_walk(vt, b, 0, 2, 0, 2);
    checks++;
    if ({got_fill, got_entry, got_n, got_addr, proto_bad} !==
        {32'd1, exp_entry, exp_n, exp_addr, 1'b0}) begin
      errors++;
      $display("FAIL flush_next_walk: got fill=%0d entry=%h n=%0d %h want 1/%h n=%0d %h",
               got_fill, got_entry, got_n, got_addr, exp_entry, exp_n, exp_addr);
    end
  endtask

  task automatic test_reset_mid_walk;
    logic [26:0] vt = 27'h1ABCDEF;
    mem.delete();
    @(negedge clk_i);
    miss_v_i = 1'b1; miss_vtag_i = vt; base_ppn_i = 28'h0FEDCBA;
    @(negedge clk_i);
    miss_v_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if ({ready_o, mem_v_o, fill_v_o, fault_v_o, mem_addr_o, fill_entry_o, fill_vtag_o} !==
        {4'b1000, 40'd0, 32'd0, 27'd0}) begin
      errors++;
      $display("FAIL reset_mid_walk: got ctl=%b addr=%h entry=%h vtag=%h want 1000/0/0/0",
               {ready_o, mem_v_o, fill_v_o, fault_v_o}, mem_addr_o, fill_entry_o, fill_vtag_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_random;
    logic [26:0] vt;
    logic [27:0] b, ppn, np;
    logic [63:0] junk;
    logic [4:0]  fl;
    int          kind;
    for (int it = 0; it < 40; it++) begin
      mem.delete();
      vt = 27'($urandom); b = 28'($urandom); ppn = b;
      for (int lvl = 2; lvl >= 0; lvl--) begin
        junk = {$urandom, $urandom} & 64'hFFFFFFC0_000003E0;
        kind = int'($urandom_range(9, 0));
        np = 28'($urandom);
        if (kind == 0) begin
          fl = {4'($urandom), 1'b0};
        end else if (kind == 1) begin
          fl = {1'($urandom), 1'($urandom), 3'b101};
        end else if (kind <= 5) begin
          fl = 5'b00001;
        end else begin
          fl = {1'($urandom), 1'($urandom), 1'($urandom), 2'b11};
          if ($urandom_range(1, 0) == 0) fl[1] = 1'b0;
          if (!fl[1]) fl[3:2] = 2'b10;
          if ($urandom_range(3, 0) != 0) np = np & ~((28'd1 << (9 * lvl)) - 28'd1);
        end
        mem[pte_addr(ppn, vt, lvl)] = junk | mk_pte(np, fl);
        if (kind < 2 || kind > 5) break;
        ppn = np;
      end
      ref_walk(vt, b);
      run_walk(vt, b, 0, 3, 0, 3);
      checks++;
      if ({got_fill, got_fault, got_vtag} !== {32'(!exp_fault), 32'(exp_fault), vt}) begin
        errors++;
        $display("FAIL random_%0d_outcome: got fill=%0d fault=%0d vtag=%h want fault=%0d vtag=%h",
                 it, got_fill, got_fault, got_vtag, exp_fault, vt);
      end
      checks++;
      if ({got_entry, got_n, got_addr, proto_bad} !== {exp_entry, exp_n, exp_addr, 1'b0}) begin
        errors++;
        $display("FAIL random_%0d_walk: got entry=%h n=%0d %h bad=%0d want %h n=%0d %h",
                 it, got_entry, got_n, got_addr, proto_bad, exp_entry, exp_n, exp_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_level();
    test_superpage();
    test_faults();
    test_stall();
    test_flush();
    test_reset_mid_walk();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
